// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : byte-stream boot loader for instruction memory. Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] loaded_words
);

  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  logic [2:0]  state_q, state_d;
  logic [15:0] n_q;
  logic [23:0] word_q;
  logic [1:0]  bcnt_q;
  logic [15:0] loaded_words_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  // One-cycle hold on entering RUN so the core is released an edge later
  logic        settle_q;

  logic        w_accept;
  logic [15:0] w_hdr;
  logic        w_last;

  assign w_accept = rx_valid && rx_ready;
  assign w_hdr    = {n_q[15:8], rx_data};
  assign w_last   = ({1'b0, loaded_words_q} + 17'd1) == {1'b0, n_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HDR_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_HI: if (w_accept) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (w_accept) begin
          if (w_hdr == 16'd0)                 state_d = S_RUN;
          else if ({1'b0, w_hdr} > CAPACITY)  state_d = S_ERROR;
          else                                state_d = S_LOAD;
        end
      end
      S_LOAD:  if (w_accept && (bcnt_q == 2'd3) && w_last) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q            <= 16'd0;
      word_q         <= 24'd0;
      bcnt_q         <= 2'd0;
      loaded_words_q <= 16'd0;
      we_q           <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      settle_q       <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      settle_q <= (state_d == S_RUN) && (state_q != S_RUN);
      if (w_accept) begin
        case (state_q)
          S_HDR_HI: n_q[15:8] <= rx_data;
          S_HDR_LO: n_q[7:0]  <= rx_data;
          S_LOAD: begin
            if (bcnt_q == 2'd3) begin
              wdata_q        <= {word_q, rx_data};
              addr_q         <= {14'd0, loaded_words_q, 2'b00};
              loaded_words_q <= loaded_words_q + 16'd1;
              we_q           <= 1'b1;
              bcnt_q         <= 2'd0;
            end else begin
              word_q <= {word_q[15:0], rx_data};
              bcnt_q <= bcnt_q + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rx_ready  = !reset && ((state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                           (state_q == S_LOAD));
    cpu_reset = reset || (state_q != S_RUN) || settle_q;
    done      = (state_q == S_RUN) && !settle_q && !reset;
    error     = (state_q == S_ERROR);
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign loaded_words = loaded_words_q;

endmodule

`default_nettype wire
